// File: rtl/bench_sequencer.sv
// bench_sequencer
//   Runs a benchmark of num_passes passes over DEPTH addresses. While the run is
//   active it gates the stimulus valid/ready pair through to the core. It counts
//   cycles and transfers, waits for the core to drain, and then presents the
//   latched results on a report handshake.
//
// Handshake semantics (stim->core and report): a beat is transferred on a rising
// clk edge where valid & ready are both 1. A producer holds valid and its payload
// stable until that edge. A consumer may drive ready regardless of valid.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        single-cycle run request / run cancel
//   num_passes          passes to run, sampled when start is accepted in IDLE
//   stim_valid/ready    handshake with the stimulus generator
//   core_valid/ready    handshake with the core under test (gated copy)
//   core_busy           core still has transfers in flight
//   busy                high in any state other than IDLE
//   report_valid/ready  result handshake
//   rep_cycles/xfers    latched cycle and transfer counts
//   rep_aborted         the reported run was ended by abort
//   state_dbg           current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 REPORT)
module bench_sequencer #(
    parameter int DEPTH  = 625,
    parameter int PASS_W = 8,
    parameter int CYC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              stim_valid,
    output logic              stim_ready,
    output logic              core_valid,
    input  logic              core_ready,
    input  logic              core_busy,
    output logic              busy,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [CYC_W-1:0]  rep_cycles,
    output logic [CYC_W-1:0]  rep_xfers,
    output logic              rep_aborted,
    output logic [1:0]        state_dbg
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [PASS_W-1:0]   passes_q;
    logic [PASS_W-1:0]   pass_cnt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [CYC_W-1:0]    cyc_cnt;
    logic [CYC_W-1:0]    xfer_cnt;

    logic                xfer;
    logic                addr_last;
    logic                final_xfer;
    logic [CYC_W-1:0]    cyc_inc;
    logic [CYC_W-1:0]    xfer_inc;
    logic                latch_run;
    logic                latch_zero;
    logic                accept_start;

    // Gating is purely combinational so the pair is forced low the moment the
    // state leaves RUN, including asynchronously on reset.
    assign core_valid   = (state == S_RUN) & stim_valid;
    assign stim_ready   = (state == S_RUN) & core_ready;
    assign busy         = (state != S_IDLE);
    assign report_valid = (state == S_REPORT);
    assign state_dbg    = state;

    assign xfer         = core_valid & core_ready;
    assign addr_last    = (addr_cnt == ADDR_W'(DEPTH - 1));
    assign final_xfer   = xfer & addr_last & (pass_cnt == passes_q - PASS_W'(1));
    assign accept_start = (state == S_IDLE) & start;

    // Saturating next values; the report latches these so the exit cycle (and
    // any transfer on an aborting cycle) is included in the reported counts.
    assign cyc_inc  = (cyc_cnt == {CYC_W{1'b1}}) ? cyc_cnt : cyc_cnt + CYC_W'(1);
    assign xfer_inc = (xfer && (xfer_cnt != {CYC_W{1'b1}})) ? xfer_cnt + CYC_W'(1)
                                                             : xfer_cnt;

    always_comb begin
        state_nxt  = state;
        latch_run  = 1'b0;
        latch_zero = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_passes != '0) begin
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt  = S_REPORT;
                        latch_zero = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // abort outranks a simultaneous final-pass completion
                if (abort) begin
                    state_nxt = S_REPORT;
                    latch_run = 1'b1;
                end else if (final_xfer) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort || !core_busy) begin
                    state_nxt = S_REPORT;
                    latch_run = 1'b1;
                end
            end
            S_REPORT: begin
                if (report_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            passes_q <= '0;
            pass_cnt <= '0;
            addr_cnt <= '0;
            cyc_cnt  <= '0;
            xfer_cnt <= '0;
        end else if (accept_start) begin
            passes_q <= num_passes;
            pass_cnt <= '0;
            addr_cnt <= '0;
            cyc_cnt  <= '0;
            xfer_cnt <= '0;
        end else if ((state == S_RUN) || (state == S_DRAIN)) begin
            cyc_cnt  <= cyc_inc;
            xfer_cnt <= xfer_inc;
            if (xfer) begin
                if (addr_last) begin
                    addr_cnt <= '0;
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end else begin
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                end
            end
        end
    end

    // Report registers hold their value until the next latch event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cycles  <= '0;
            rep_xfers   <= '0;
            rep_aborted <= 1'b0;
        end else if (latch_zero) begin
            rep_cycles  <= '0;
            rep_xfers   <= '0;
            rep_aborted <= 1'b0;
        end else if (latch_run) begin
            rep_cycles  <= cyc_inc;
            rep_xfers   <= xfer_inc;
            rep_aborted <= abort;
        end
    end

endmodule

// File: tb/tb_bench_sequencer.sv
// tb_bench_sequencer
//   Directed bench for bench_sequencer with DEPTH=4. A table of run records
//   {passes, ready pattern, drain length, expected counts} is applied in a loop,
//   followed by hand-written abort, priority and reset sequences.
module tb_bench_sequencer;

    localparam int DEPTH  = 4;
    localparam int PASS_W = 8;
    localparam int CYC_W  = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [PASS_W-1:0] num_passes;
    logic              stim_valid;
    logic              stim_ready;
    logic              core_valid;
    logic              core_ready;
    logic              core_busy;
    logic              busy;
    logic              report_valid;
    logic              report_ready;
    logic [CYC_W-1:0]  rep_cycles;
    logic [CYC_W-1:0]  rep_xfers;
    logic              rep_aborted;
    logic [1:0]        state_dbg;

    int vec_cnt;
    int err_cnt;

    bench_sequencer #(.DEPTH(DEPTH), .PASS_W(PASS_W), .CYC_W(CYC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .num_passes   (num_passes),
        .stim_valid   (stim_valid),
        .stim_ready   (stim_ready),
        .core_valid   (core_valid),
        .core_ready   (core_ready),
        .core_busy    (core_busy),
        .busy         (busy),
        .report_valid (report_valid),
        .report_ready (report_ready),
        .rep_cycles   (rep_cycles),
        .rep_xfers    (rep_xfers),
        .rep_aborted  (rep_aborted),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int passes;
        bit toggle;      // core_ready 1,0,1,0... from the first RUN cycle
        int drain;       // core_busy cycles after the final transfer
        int exp_xfers;
        int exp_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_report(input logic [31:0] exp_x);
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_report_valid", report_valid, 0);
        check("idle_rep_hold", rep_xfers, exp_x);
    endtask

    task automatic run_vec(input vec_t v);
        int  xf;
        int  after;
        int  obs_cv;
        int  exp_run;
        bit  done;
        bit  drain_rdy;
        bit  got;
        xf = 0; after = 0; obs_cv = 0; done = 0; drain_rdy = 0; got = 0;
        num_passes = PASS_W'(v.passes);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (report_valid) begin
                got = 1;
                break;
            end
            stim_valid = 1'b1;
            core_ready = v.toggle ? ((k % 2) == 0) : 1'b1;
            if (done) begin
                after++;
                core_busy = (after <= v.drain);
            end else begin
                core_busy = 1'b0;
            end
            @(negedge clk);
            if (core_valid) obs_cv++;
            if (core_valid && core_ready) begin
                xf++;
                if (xf == v.passes * DEPTH) done = 1;
            end
            if (state_dbg == 2'd2 && stim_ready) drain_rdy = 1;
            tick();
        end
        stim_valid = 1'b0;
        core_ready = 1'b0;
        core_busy  = 1'b0;
        exp_run = (v.passes == 0) ? 0 : v.exp_cycles - v.drain - 1;
        check("report_reached", 32'(got), 1);
        check("rep_xfers", rep_xfers, 32'(v.exp_xfers));
        check("rep_cycles", rep_cycles, 32'(v.exp_cycles));
        check("rep_aborted", rep_aborted, 0);
        check("observed_xfers", 32'(xf), 32'(v.exp_xfers));
        check("core_valid_cycles", 32'(obs_cv), 32'(exp_run));
        check("drain_stim_ready", 32'(drain_rdy), 0);
        accept_report(32'(v.exp_xfers));
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; num_passes = '0;
        stim_valid = 1'b1; core_ready = 1'b1; core_busy = 1'b0; report_ready = 1'b0;

        vecs[0] = '{passes: 2, toggle: 0, drain: 0, exp_xfers: 8,  exp_cycles: 9};
        vecs[1] = '{passes: 2, toggle: 1, drain: 0, exp_xfers: 8,  exp_cycles: 16};
        vecs[2] = '{passes: 0, toggle: 0, drain: 0, exp_xfers: 0,  exp_cycles: 0};
        vecs[3] = '{passes: 1, toggle: 0, drain: 5, exp_xfers: 4,  exp_cycles: 10};
        vecs[4] = '{passes: 3, toggle: 0, drain: 2, exp_xfers: 12, exp_cycles: 15};
        vecs[5] = '{passes: 1, toggle: 1, drain: 1, exp_xfers: 4,  exp_cycles: 9};

        // reset state, with valid/ready driven high to show gating
        #12;
        check("rst_busy", busy, 0);
        check("rst_report_valid", report_valid, 0);
        check("rst_core_valid", core_valid, 0);
        check("rst_stim_ready", stim_ready, 0);
        check("rst_rep_cycles", rep_cycles, 0);
        check("rst_rep_xfers", rep_xfers, 0);
        check("rst_rep_aborted", rep_aborted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stim_valid = 1'b0; core_ready = 1'b0;
        tick();

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_report", report_valid, 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // abort after 3 transfers, with a start during RUN
        num_passes = 8'd2; start = 1'b1;
        tick();
        start = 1'b0; stim_valid = 1'b1; core_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);
            tick();
        end
        start = 1'b0; stim_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; core_ready = 1'b0;
        check("abort_report_valid", report_valid, 1);
        check("abort_rep_aborted", rep_aborted, 1);
        check("abort_rep_xfers", rep_xfers, 3);
        check("abort_rep_cycles", rep_cycles, 4);
        // report_ready low: results stable; abort/start in REPORT ignored
        for (int k = 0; k < 3; k++) begin
            abort = (k == 0);
            start = (k == 1);
            tick();
            check("hold_report_valid", report_valid, 1);
            check("hold_rep_xfers", rep_xfers, 3);
            check("hold_rep_cycles", rep_cycles, 4);
            check("hold_rep_aborted", rep_aborted, 1);
        end
        abort = 1'b0; start = 1'b0;
        accept_report(3);

        // abort together with the final-pass transfer
        num_passes = 8'd1; start = 1'b1;
        tick();
        start = 1'b0; stim_valid = 1'b1; core_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; stim_valid = 1'b0; core_ready = 1'b0;
        check("fin_abort_report", report_valid, 1);
        check("fin_abort_aborted", rep_aborted, 1);
        check("fin_abort_xfers", rep_xfers, 4);
        check("fin_abort_cycles", rep_cycles, 4);
        accept_report(4);

        // abort together with the DRAIN exit
        num_passes = 8'd1; start = 1'b1; core_busy = 1'b1;
        tick();
        start = 1'b0; stim_valid = 1'b1; core_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        check("drain_state", state_dbg, 2);
        check("drain_stim_ready_low", stim_ready, 0);
        check("drain_core_valid_low", core_valid, 0);
        tick();
        core_busy = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; stim_valid = 1'b0; core_ready = 1'b0;
        check("drain_abort_report", report_valid, 1);
        check("drain_abort_aborted", rep_aborted, 1);
        check("drain_abort_xfers", rep_xfers, 4);
        check("drain_abort_cycles", rep_cycles, 6);
        accept_report(4);

        // reset mid-RUN discards the run
        num_passes = 8'd2; start = 1'b1;
        tick();
        start = 1'b0; stim_valid = 1'b1; core_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_core_valid", core_valid, 0);
        check("midrst_stim_ready", stim_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rep_xfers", rep_xfers, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (report_valid || busy) seen++;
            end
            check("midrst_no_report", 32'(seen), 0);
        end
        stim_valid = 1'b0; core_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
